// File: rtl/serial_rx_aligner_if.sv
// Serial-line side of the QQTX receive aligner: one serial bit in, aligned byte stream out.
interface serial_rx_aligner_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;
  logic       IDLE_OUT;

  modport master (
    output data_in,
    input  data_out, valid_out, byte_strobe, active, IDLE_OUT
  );

  modport slave (
    input  data_in,
    output data_out, valid_out, byte_strobe, active, IDLE_OUT
  );
endinterface

// File: rtl/serial_rx_aligner.sv
// QQTX receive front end: deserializes MSB-first bits, locks onto the COMMA byte boundary,
// and emits one aligned byte every 8 clocks once BC_COUNT consecutive aligned commas are seen.
module serial_rx_aligner #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned BC_COUNT = 4
) (
  input  logic                clk_32f,
  input  logic                reset,
  serial_rx_aligner_if.slave  rx
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam logic [3:0] BC_TARGET = BC_COUNT[3:0];

  state_e     state_q, state_d;
  logic [7:0] sr_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       idle_q, idle_d;
  logic       strobe_q, strobe_d;
  logic       active_q, active_d;
  logic       is_comma_s;
  logic       boundary_s;

  assign is_comma_s = (sr_q == COMMA);

  // Next-state and output decode; SEARCH tests every bit offset, ALIGN/ACTIVE only every 8th cycle.
  always_comb begin
    state_d    = state_q;
    bc_cnt_d   = bc_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    idle_d     = idle_q;
    strobe_d   = 1'b0;
    boundary_s = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        if (is_comma_s) begin
          boundary_s = 1'b1;
          bc_cnt_d   = 4'd1;
          state_d    = (BC_TARGET == 4'd1) ? ST_ACTIVE : ST_ALIGN;
        end else begin
          state_d    = ST_SEARCH;
        end
      end
      ST_ALIGN: begin
        if (bit_cnt_q == 3'd7) begin
          boundary_s = 1'b1;
          if (is_comma_s) begin
            // Saturate at the target so the count can never wrap.
            if ((bc_cnt_q + 4'd1) >= BC_TARGET) begin
              bc_cnt_d = BC_TARGET;
              state_d  = ST_ACTIVE;
            end else begin
              bc_cnt_d = bc_cnt_q + 4'd1;
              state_d  = ST_ALIGN;
            end
          end else begin
            bc_cnt_d = 4'd0;
            state_d  = ST_SEARCH;
          end
        end else begin
          boundary_s = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (bit_cnt_q == 3'd7) begin
          boundary_s = 1'b1;
          data_d     = sr_q;
          valid_d    = ~is_comma_s;
          idle_d     = is_comma_s;
          strobe_d   = 1'b1;
        end else begin
          boundary_s = 1'b0;
        end
      end
      default: begin
        state_d  = ST_SEARCH;
        bc_cnt_d = 4'd0;
      end
    endcase

    if (boundary_s) begin
      bit_cnt_d = 3'd0;
    end else begin
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    // No loss-of-sync exit: once entered, active holds until reset.
    active_d = active_q | (state_d == ST_ACTIVE);
  end

  // State, shift register and registered outputs.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SEARCH;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      idle_q    <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= {sr_q[6:0], rx.data_in};
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      idle_q    <= idle_d;
      strobe_q  <= strobe_d;
      active_q  <= active_d;
    end
  end

  assign rx.data_out    = data_q;
  assign rx.valid_out   = valid_q;
  assign rx.IDLE_OUT    = idle_q;
  assign rx.byte_strobe = strobe_q;
  assign rx.active      = active_q;

endmodule

// File: tb/tb_serial_rx_aligner.sv
// Bench for serial_rx_aligner: per-cycle comparison against a bit-history reference model,
// a byte table for the active data path, and hand-written alignment/reset sequences.
module tb_serial_rx_aligner;

  localparam logic [7:0] COMMA    = 8'hBC;
  localparam int         BC_COUNT = 4;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;

  serial_rx_aligner_if rx ();

  serial_rx_aligner #(.COMMA(COMMA), .BC_COUNT(BC_COUNT)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .rx      (rx)
  );

  always #5 clk_32f = ~clk_32f;

  int checks = 0;
  int errors = 0;

  // Reference model: raw bit history since reset, boundaries tracked by edge index distance.
  bit         hist[$];
  int         m_mode;     // 0 searching, 1 counting commas, 2 active
  int         m_last;
  int         m_cnt;
  int         m_edge;
  logic [7:0] m_data;
  logic       m_valid, m_idle, m_strobe, m_active;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_idle;
  } vec_t;

  vec_t tab [7];

  task automatic model_reset();
    hist.delete();
    m_mode   = 0;
    m_last   = 0;
    m_cnt    = 0;
    m_edge   = 0;
    m_data   = 8'h00;
    m_valid  = 1'b0;
    m_idle   = 1'b0;
    m_strobe = 1'b0;
    m_active = 1'b0;
  endtask

  // Last eight bits received before this edge, oldest first; bits before reset read as 0.
  function automatic logic [7:0] model_window();
    logic [7:0] w;
    int         idx;
    w = 8'h00;
    for (int i = 8; i >= 1; i--) begin
      idx = hist.size() - i;
      w   = {w[6:0], (idx >= 0) ? hist[idx] : 1'b0};
    end
    return w;
  endfunction

  task automatic model_edge(input bit b);
    logic [7:0] w;
    w        = model_window();
    m_strobe = 1'b0;
    if (m_mode == 0) begin
      if (w == COMMA) begin
        m_cnt  = 1;
        m_last = m_edge;
        m_mode = (m_cnt >= BC_COUNT) ? 2 : 1;
      end
    end else if (m_edge - m_last == 8) begin
      m_last = m_edge;
      if (m_mode == 1) begin
        if (w == COMMA) begin
          m_cnt = m_cnt + 1;
          if (m_cnt >= BC_COUNT) m_mode = 2;
        end else begin
          m_cnt  = 0;
          m_mode = 0;
        end
      end else begin
        m_data   = w;
        m_valid  = (w != COMMA);
        m_idle   = (w == COMMA);
        m_strobe = 1'b1;
      end
    end
    m_active = (m_mode == 2);
    hist.push_back(b);
    m_edge = m_edge + 1;
  endtask

  function automatic logic [11:0] dut_pack();
    return {rx.active, rx.byte_strobe, rx.valid_out, rx.IDLE_OUT, rx.data_out};
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at t=%0t: got %03h expected %03h (act,strb,vld,idle,data)", name, $time, got, exp);
    end
  endtask

  task automatic check_active(input string name, input logic exp);
    checks = checks + 1;
    if (rx.active !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at t=%0t: active got %b expected %b", name, $time, rx.active, exp);
    end
  endtask

  // One serial bit: drive, clock, advance model, compare on the falling edge.
  task automatic step(input bit b);
    rx.data_in = b;
    @(posedge clk_32f);
    model_edge(b);
    @(negedge clk_32f);
    check("model", dut_pack(), {m_active, m_strobe, m_valid, m_idle, m_data});
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i]);
  endtask

  task automatic send_tail(input logic [7:0] v);
    for (int i = 6; i >= 0; i--) step(v[i]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check("reset_outputs", dut_pack(), 12'h000);
    repeat (2) @(negedge clk_32f);
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] bc_v;
    logic [7:0] rb;
    int         kind;

    bc_v   = COMMA;
    tab[0] = '{8'hBC, 8'hBC, 1'b0, 1'b1};
    tab[1] = '{8'hBC, 8'hBC, 1'b0, 1'b1};
    tab[2] = '{8'hBC, 8'hBC, 1'b0, 1'b1};
    tab[3] = '{8'h12, 8'h12, 1'b1, 1'b0};
    tab[4] = '{8'h34, 8'h34, 1'b1, 1'b0};
    tab[5] = '{8'hFF, 8'hFF, 1'b1, 1'b0};
    tab[6] = '{8'hBC, 8'hBC, 1'b0, 1'b1};

    rx.data_in = 1'b0;
    #1;

    // Idle line after reset: nothing should ever come out.
    do_reset();
    repeat (64) step(1'b0);
    check("idle_zero_line", dut_pack(), 12'h000);

    // Random phase, then commas; active rises one cycle after the 4th comma's last bit.
    do_reset();
    repeat (3) step(1'($urandom_range(0, 1)));
    repeat (4) send_byte(bc_v);
    check_active("active_before_4th_eval", 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(tab[i].din[7]);
      if (i == 0) begin
        check_active("active_rise", 1'b1);
      end else begin
        check($sformatf("table_row%0d", i - 1), dut_pack(),
              {1'b1, 1'b1, tab[i-1].exp_valid, tab[i-1].exp_idle, tab[i-1].exp_data});
      end
      send_tail(tab[i].din);
    end
    step(bc_v[7]);
    check("table_row6", dut_pack(), {1'b1, 1'b1, tab[6].exp_valid, tab[6].exp_idle, tab[6].exp_data});
    send_tail(bc_v);

    // Broken comma run during alignment restarts the count.
    do_reset();
    send_byte(bc_v);
    send_byte(bc_v);
    send_byte(8'h55);
    step(bc_v[7]);
    check_active("align_break_no_active", 1'b0);
    send_tail(bc_v);
    repeat (3) send_byte(bc_v);
    check_active("align_restart_pending", 1'b0);
    step(bc_v[7]);
    check_active("align_restart_active", 1'b1);
    send_tail(bc_v);

    // Comma at bit offset 1 of 5E,00 is found once but not confirmed.
    do_reset();
    send_byte(8'h5E);
    repeat (4) send_byte(8'h00);
    check_active("false_comma_no_active", 1'b0);

    // Reset in the middle of a data byte while active.
    do_reset();
    repeat (4) send_byte(bc_v);
    step(bc_v[7]);
    check_active("pre_reset_active", 1'b1);
    send_tail(bc_v);
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    check("pre_reset_idle_byte", dut_pack(), {1'b1, 1'b0, 1'b0, 1'b1, 8'hBC});
    #2;
    do_reset();
    repeat (3) send_byte(bc_v);
    step(bc_v[7]);
    check_active("post_reset_3_commas", 1'b0);
    send_tail(bc_v);
    step(bc_v[7]);
    check_active("post_reset_4_commas", 1'b1);
    send_tail(bc_v);

    // Randomized traffic: comma-heavy bytes, random data and occasional bit slips.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      if (r[0] == 1'b0) repeat (5) send_byte(bc_v);
      for (int k = 0; k < 150; k++) begin
        kind = int'($urandom_range(0, 9));
        if (kind < 5) begin
          send_byte(bc_v);
        end else if (kind < 9) begin
          rb = 8'($urandom_range(0, 255));
          send_byte(rb);
        end else begin
          repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx_aligner.md
Name: serial_rx_aligner

Overview:
Receive-side front end for the serialized QQTX link. It sits at the far end of the 1-bit serial line and deserializes MSB-first bits into bytes. It finds the byte boundary by detecting the COMMA idle symbol and declares the link active after BC_COUNT consecutive aligned commas. It then delivers data bytes with a valid flag, so downstream byte-to-lane demux stages can rebuild the four 8-bit lanes.

Parameters:
COMMA, 8'hBC, idle/alignment symbol inserted by the transmitter
BC_COUNT, 4, consecutive aligned commas required to declare link active (range 1..15)

Ports:
clk_32f  input  1  serial bit clock, only clock of the block, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
data_in  input  1  serial bit, MSB of each byte first
data_out  output  8  last received aligned byte
valid_out  output  1  data_out is a data byte (not COMMA), held with data_out
byte_strobe  output  1  one-cycle pulse when data_out/valid_out/IDLE_OUT update
active  output  1  link aligned and active
IDLE_OUT  output  1  last aligned byte received in ACTIVE was COMMA

Behaviour:
- Reset (reset==0, asynchronous): state=SEARCH; sr=0, bit_cnt=0, bc_cnt=0; all outputs 0. Outputs stay 0 until reset deasserts and a valid ACTIVE boundary occurs.
- Shift register sr[7:0] runs every cycle out of reset: sr <= {sr[6:0], data_in}.
- Boundary cycle: a cycle in which sr holds a complete aligned byte.
- bit_cnt (3 bits):
  - Cleared to 0 on the cycle after any boundary.
  - Otherwise increments and wraps 7->0.
  - In ALIGN/ACTIVE, the next boundary is the cycle with bit_cnt==7, i.e. exactly 8 cycles after the previous boundary.
- State SEARCH: every cycle is a candidate boundary.
  - If sr==COMMA: bc_cnt<=1, bit_cnt<=0.
  - Then go to ACTIVE if BC_COUNT==1, else go to ALIGN.
  - Comma detection is bit-wise: any bit offset is found.
- State ALIGN: evaluated only on boundaries.
  - If sr==COMMA: bc_cnt++. When the new value equals BC_COUNT, go to ACTIVE.
  - If sr!=COMMA: bc_cnt<=0 and go to SEARCH. The comparison at the very next cycle is a fresh bit-wise search, so no data is lost from re-search.
- State ACTIVE: evaluated only on boundaries. Registered on the following cycle:
  - data_out<=sr
  - valid_out<=(sr!=COMMA)
  - IDLE_OUT<=(sr==COMMA)
  - byte_strobe=1 for exactly one cycle
- Transition into ACTIVE: the comma that completes the count is not emitted as a byte.
- Between boundaries, data_out, valid_out and IDLE_OUT hold their values; byte_strobe=0.
- active:
  - Rises the cycle after the transition into ACTIVE and stays high until reset.
  - There is no loss-of-sync exit; the link layer handles retrain via reset.
- Latency: the last bit of a byte is sampled into sr at cycle t (boundary at t). Outputs change at t+1. First output strobe arrives 8 cycles after the completing comma.
- Simultaneous events: reset wins over every other condition. Reset mid-ACTIVE clears all outputs in the same cycle (asynchronous), and alignment restarts from SEARCH.
- bc_cnt saturates at BC_COUNT; it never wraps.
- data_in is sampled directly; it is synchronous to clk_32f from the transmitter.

Test Plan:
- Reset, then data_in=0 for 64 cycles -> state SEARCH; active, valid_out, byte_strobe, IDLE_OUT, data_out all 0.
- 3 random bits, then 6x 8'hBC MSB-first -> active rises 1 cycle after the 4th BC's last bit. First strobe follows 8 cycles later with IDLE_OUT=1, valid_out=0, data_out=8'hBC.
- After active, send 8'hBC then bytes 8'h12, 8'h34, 8'hFF, 8'hBC -> strobes every 8 cycles. data_out/valid_out go 12/1, 34/1, FF/1, BC/0; IDLE_OUT=1 only for the BC entries.
- In ALIGN, send BC, BC, 8'h55, then 4x BC -> active stays 0 after the 55 byte; alignment restarts, and active rises after the later 4 BCs.
- Misaligned false comma: bytes 8'h5E,8'h00 (bits contain 0xBC at offset 1), no true BCs -> search hits once, then the next boundary check fails and the block returns to SEARCH; active stays 0.
- Assert reset mid-ACTIVE during a data byte -> all outputs 0 immediately. After release, 4 BCs are required again before active=1.
